// File: rtl/vga_window_addr_gen_if.sv
// Raster-counter and address bus between the VGA timing generator, the
// window address generator and the video memory read port.
interface vga_window_addr_gen_if #(
  parameter int CNT_W  = 10,
  parameter int ADDR_W = 32,
  parameter int SEL_W  = 1
);
  logic [CNT_W-1:0]  hcnt;
  logic [CNT_W-1:0]  vcnt;
  logic [SEL_W-1:0]  image_select;
  logic [ADDR_W-1:0] video_address;
  logic              in_window;
  logic              frame_start;
  logic [SEL_W-1:0]  active_slot;

  modport master (
    output hcnt, vcnt, image_select,
    input  video_address, in_window, frame_start, active_slot
  );

  modport slave (
    input  hcnt, vcnt, image_select,
    output video_address, in_window, frame_start, active_slot
  );
endinterface

// File: rtl/vga_window_addr_gen.sv
// Maps raster counters to a framebuffer address inside one of NUM_IMAGES
// stacked image slots; the row base is accumulated per line, no multiply per pixel.
module vga_window_addr_gen #(
  parameter int              CNT_W      = 10,
  parameter int              ADDR_W     = 32,
  parameter int              XPOS       = 150,
  parameter int              YPOS       = 80,
  parameter int              IMG_W      = 256,
  parameter int              IMG_H      = 256,
  parameter int              NUM_IMAGES = 2,
  parameter int              SEL_W      = 1,
  parameter logic [ADDR_W-1:0] IMG_STRIDE = 'h10000,
  parameter logic [ADDR_W-1:0] BLACK_ADDR = 'hFFFF
) (
  input  logic                  clk,
  input  logic                  rst,
  vga_window_addr_gen_if.slave  bus
);
  // Counter comparisons are done one bit wider so XPOS+IMG_W may reach 2**CNT_W.
  localparam int CW1 = CNT_W + 1;
  localparam int SW1 = SEL_W + 1;
  localparam logic [CW1-1:0]    X0       = CW1'(XPOS);
  localparam logic [CW1-1:0]    X1       = CW1'(XPOS + IMG_W);
  localparam logic [CW1-1:0]    Y0       = CW1'(YPOS);
  localparam logic [CW1-1:0]    Y1       = CW1'(YPOS + IMG_H);
  localparam logic [CNT_W-1:0]  X0_CNT   = CNT_W'(XPOS);
  localparam logic [SW1-1:0]    NUM_SLOT = SW1'(NUM_IMAGES);
  localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(IMG_W);

  logic [CNT_W-1:0]  vcnt_q_reg;
  logic [ADDR_W-1:0] row_base_reg, row_base_next;
  logic              base_ok_reg, base_ok_next;
  logic [SEL_W-1:0]  active_slot_reg, active_slot_next;
  logic [ADDR_W-1:0] video_address_reg, video_address_next;
  logic              in_window_reg;
  logic              frame_start_reg;

  logic              line_chg;
  logic              frame_evt;
  logic              win;
  logic [CW1-1:0]    h_ext;
  logic [CW1-1:0]    v_ext;

  always_comb begin
    h_ext     = {1'b0, bus.hcnt};
    v_ext     = {1'b0, bus.vcnt};
    line_chg  = (bus.vcnt != vcnt_q_reg);
    frame_evt = line_chg && (bus.vcnt == '0);

    active_slot_next = active_slot_reg;
    if (frame_evt && ({1'b0, bus.image_select} < NUM_SLOT))
      active_slot_next = bus.image_select;

    // The YPOS load uses the slot latched this same cycle, so YPOS=0 picks up the new slot.
    row_base_next = row_base_reg;
    base_ok_next  = base_ok_reg;
    if (line_chg) begin
      if (v_ext == Y0) begin
        row_base_next = ADDR_W'(active_slot_next) * IMG_STRIDE;
        base_ok_next  = 1'b1;
      end else if ((v_ext > Y0) && (v_ext < Y1)) begin
        row_base_next = row_base_reg + ROW_STEP;
      end
    end

    win = base_ok_next && (h_ext >= X0) && (h_ext < X1) && (v_ext >= Y0) && (v_ext < Y1);
    video_address_next = win ? row_base_next + ADDR_W'(bus.hcnt - X0_CNT) : BLACK_ADDR;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vcnt_q_reg        <= '0;
      row_base_reg      <= '0;
      base_ok_reg       <= 1'b0;
      active_slot_reg   <= '0;
      video_address_reg <= BLACK_ADDR;
      in_window_reg     <= 1'b0;
      frame_start_reg   <= 1'b0;
    end else begin
      vcnt_q_reg        <= bus.vcnt;
      row_base_reg      <= row_base_next;
      base_ok_reg       <= base_ok_next;
      active_slot_reg   <= active_slot_next;
      video_address_reg <= video_address_next;
      in_window_reg     <= win;
      frame_start_reg   <= frame_evt;
    end
  end

  assign bus.video_address = video_address_reg;
  assign bus.in_window     = in_window_reg;
  assign bus.frame_start   = frame_start_reg;
  assign bus.active_slot   = active_slot_reg;
endmodule

// File: tb/tb_vga_window_addr_gen.sv
// Directed raster scans of vga_window_addr_gen checked every cycle against a
// frame-level arithmetic model, with literal address pins at key coordinates.
module tb_vga_window_addr_gen;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  vga_window_addr_gen_if #(.CNT_W(10), .ADDR_W(32), .SEL_W(1)) bus ();
  vga_window_addr_gen_if #(.CNT_W(10), .ADDR_W(32), .SEL_W(2)) bus3 ();

  vga_window_addr_gen #(.NUM_IMAGES(2), .SEL_W(1)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  vga_window_addr_gen #(.NUM_IMAGES(3), .SEL_W(2)) dut3 (
    .clk(clk), .rst(rst), .bus(bus3)
  );

  typedef struct {
    int          frame;
    int          h;
    int          v;
    logic [31:0] addr;
    logic        win;
  } pin_t;

  pin_t pins[$];
  int   hlist[8] = '{0, 149, 150, 151, 230, 405, 406, 500};
  int   n_vec = 0;
  int   n_err = 0;

  // Model state: the frame's slot is whatever was active when row 80 was entered.
  int   m_prev_v, m_slot, m_valid, m_fslot;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_prev_v = 0; m_slot = 0; m_valid = 0; m_fslot = 0;
  endtask

  task automatic apply(int h, int v);
    logic [31:0] e_addr;
    logic        e_win, e_fs;
    bit          line;
    @(negedge clk);
    bus.hcnt = h[9:0];
    bus.vcnt = v[9:0];
    line = (v != m_prev_v);
    e_fs = line && (v == 0);
    if (e_fs && int'(bus.image_select) < 2) m_slot = int'(bus.image_select);
    if (line && v == 80) begin
      m_valid = 1;
      m_fslot = m_slot;
    end
    m_prev_v = v;
    e_win  = (m_valid != 0) && h >= 150 && h < 406 && v >= 80 && v < 336;
    e_addr = e_win ? 32'(m_fslot) * 32'h10000 + 32'((v - 80) * 256 + (h - 150)) : 32'hFFFF;
    @(posedge clk);
    #1;
    check($sformatf("addr(%0d,%0d)", h, v), bus.video_address, e_addr);
    check($sformatf("win(%0d,%0d)", h, v), 32'(bus.in_window), 32'(e_win));
    check($sformatf("fs(%0d,%0d)", h, v), 32'(bus.frame_start), 32'(e_fs));
    check($sformatf("slot(%0d,%0d)", h, v), 32'(bus.active_slot), 32'(m_slot));
  endtask

  task automatic check_pins(int frame, int h, int v);
    foreach (pins[i]) begin
      if (pins[i].frame == frame && pins[i].h == h && pins[i].v == v) begin
        $display("pin f%0d (%0d,%0d): addr=%h win=%0b", frame, h, v,
                 bus.video_address, bus.in_window);
        check($sformatf("pin_addr f%0d(%0d,%0d)", frame, h, v), bus.video_address, pins[i].addr);
        check($sformatf("pin_win f%0d(%0d,%0d)", frame, h, v), 32'(bus.in_window), 32'(pins[i].win));
      end
    end
  endtask

  task automatic scan(int frame, int v0, int v1, int hold);
    for (int v = v0; v <= v1; v++) begin
      foreach (hlist[i]) begin
        for (int k = 0; k < hold; k++) begin
          apply(hlist[i], v);
          check_pins(frame, hlist[i], v);
        end
      end
    end
  endtask

  task automatic apply3(int v, int sel, int e_slot, int e_fs);
    @(negedge clk);
    bus3.vcnt = v[9:0];
    bus3.image_select = sel[1:0];
    @(posedge clk);
    #1;
    $display("slot3 v=%0d sel=%0d: active_slot=%0d frame_start=%0b", v, sel,
             bus3.active_slot, bus3.frame_start);
    check($sformatf("slot3(v=%0d,sel=%0d)", v, sel), 32'(bus3.active_slot), 32'(e_slot));
    check($sformatf("fs3(v=%0d,sel=%0d)", v, sel), 32'(bus3.frame_start), 32'(e_fs));
  endtask

  initial begin
    pins.push_back('{0, 150, 80,  32'h0,     1'b1});
    pins.push_back('{0, 405, 80,  32'hFF,    1'b1});
    pins.push_back('{0, 150, 81,  32'h100,   1'b1});
    pins.push_back('{0, 405, 335, 32'hFFFF,  1'b1});
    pins.push_back('{0, 149, 80,  32'hFFFF,  1'b0});
    pins.push_back('{0, 406, 80,  32'hFFFF,  1'b0});
    pins.push_back('{0, 150, 79,  32'hFFFF,  1'b0});
    pins.push_back('{0, 150, 336, 32'hFFFF,  1'b0});
    pins.push_back('{1, 230, 200, 32'h7850,  1'b1});
    pins.push_back('{1, 230, 300, 32'hDC50,  1'b1});
    pins.push_back('{2, 150, 80,  32'h10000, 1'b1});
    pins.push_back('{2, 150, 81,  32'h10100, 1'b1});
    pins.push_back('{2, 405, 335, 32'h1FFFF, 1'b1});
    pins.push_back('{3, 150, 200, 32'hFFFF,  1'b0});
    pins.push_back('{4, 150, 80,  32'h0,     1'b1});
    pins.push_back('{4, 151, 80,  32'h1,     1'b1});

    rst = 1'b1;
    bus.hcnt = '0;  bus.vcnt = '0;  bus.image_select = '0;
    bus3.hcnt = '0; bus3.vcnt = '0; bus3.image_select = '0;
    model_reset();
    @(posedge clk);
    #1;
    check("reset_addr", bus.video_address, 32'hFFFF);
    check("reset_win", 32'(bus.in_window), 32'd0);
    check("reset_fs", 32'(bus.frame_start), 32'd0);
    check("reset_slot", 32'(bus.active_slot), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Frame 0: slot 0, window geometry and exclusive edges.
    scan(0, 0, 524, 1);

    // Frame 1: request slot 1 mid-frame; the running frame stays on slot 0.
    scan(1, 0, 199, 1);
    bus.image_select = 1'b1;
    scan(1, 200, 524, 1);

    // Frame 2: slot 1 takes over at vcnt->0; hcnt held two clocks per value.
    apply(0, 0);
    check("fs_pulse", 32'(bus.frame_start), 32'd1);
    check("slot_switch", 32'(bus.active_slot), 32'd1);
    apply(0, 0);
    check("fs_one_cycle", 32'(bus.frame_start), 32'd0);
    scan(2, 0, 524, 2);

    // Frame 3: asynchronous reset at vcnt=150 while slot 1 is active.
    scan(3, 0, 149, 1);
    @(negedge clk);
    bus.hcnt = 10'd200;
    bus.vcnt = 10'd150;
    bus.image_select = 1'b0;
    rst = 1'b1;
    #1;
    check("async_rst_addr", bus.video_address, 32'hFFFF);
    check("async_rst_win", 32'(bus.in_window), 32'd0);
    check("async_rst_slot", 32'(bus.active_slot), 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    scan(3, 150, 524, 1);

    // Frame 4: window valid again from row 80.
    scan(4, 0, 524, 1);

    // Three-slot build: out-of-range select 3 must not change the slot.
    apply3(1, 2, 0, 0);
    apply3(0, 2, 2, 1);
    apply3(1, 3, 2, 0);
    apply3(0, 3, 2, 1);
    apply3(5, 1, 2, 0);
    apply3(0, 1, 1, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
